// File: rtl/bus_arbiter_n_if.sv
// Bundle of the N-master request/response bus and the single target port of bus_arbiter_n.
// slave: the arbiter's view; master: the view of the masters and the target that surround it.
interface bus_arbiter_n_if #(
    parameter int NMASTERS = 3,
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [NMASTERS*ADDR_W-1:0] m_address;
    logic [NMASTERS-1:0]        m_read;
    logic [NMASTERS-1:0]        m_write;
    logic [NMASTERS*DATA_W-1:0] m_writedata;
    logic [NMASTERS*BE_W-1:0]   m_byteena;
    logic [NMASTERS-1:0]        m_wait;
    logic [DATA_W-1:0]          m_readdata;
    logic [NMASTERS-1:0]        m_readdatavalid;

    logic [ADDR_W-1:0]          t_address;
    logic                       t_read;
    logic                       t_write;
    logic [DATA_W-1:0]          t_writedata;
    logic [BE_W-1:0]            t_byteena;
    logic                       t_wait;
    logic [DATA_W-1:0]          t_readdata;
    logic                       t_readdatavalid;

    modport slave (
        input  m_address, m_read, m_write, m_writedata, m_byteena,
        input  t_wait, t_readdata, t_readdatavalid,
        output m_wait, m_readdata, m_readdatavalid,
        output t_address, t_read, t_write, t_writedata, t_byteena
    );

    modport master (
        output m_address, m_read, m_write, m_writedata, m_byteena,
        output t_wait, t_readdata, t_readdatavalid,
        input  m_wait, m_readdata, m_readdatavalid,
        input  t_address, t_read, t_write, t_writedata, t_byteena
    );
endinterface

// File: rtl/bus_arbiter_n.sv
// N-master to one-target arbiter with in-order read tagging; zero-cycle grant, read data routed combinationally.
// Backpressure: m_wait follows t_wait for the granted master and also stalls reads while the tag FIFO is full; BUS_ARB_ROUND_ROBIN_EN selects round-robin.
module bus_arbiter_n #(
    parameter int NMASTERS        = 3,
    parameter int ADDR_W          = 30,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_n_if.slave bus,
    output logic           overflow_err
);
    localparam int IDX_W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    lock_idx, lock_idx_nxt;
    logic [NMASTERS-1:0] req;
    logic [IDX_W-1:0]    win_idx, grant_idx;
    logic                win_vld, grant_vld;
    logic                grant_rd, grant_wr;
    logic                accept, fifo_full, push, pop;
    logic [IDX_W-1:0]    tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count;

    assign req       = bus.m_read | bus.m_write;
    assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING));

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // Search begins one past the last accepted master and wraps.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NMASTERS; k++) begin
            cand     = (int'(rr_ptr) + k) % NMASTERS;
            cand_idx = IDX_W'(cand);
            if (!win_vld && req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= grant_idx;
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NMASTERS - 1; k >= 0; k--) begin
            if (req[IDX_W'(k)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
    end
`endif

    // A locked master keeps the port until accepted; reset masks every grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!rst) begin
            if (state == LOCKED) begin
                grant_vld = 1'b1;
                grant_idx = lock_idx;
            end else begin
                grant_vld = win_vld;
                grant_idx = win_idx;
            end
        end
    end

    assign grant_wr = grant_vld & bus.m_write[grant_idx];
    assign grant_rd = grant_vld & bus.m_read[grant_idx] & ~grant_wr;
    assign accept   = (grant_wr | grant_rd) & ~bus.t_wait & ~(grant_rd & fifo_full);

    assign bus.t_read      = grant_rd & ~fifo_full;
    assign bus.t_write     = grant_wr;
    assign bus.t_address   = bus.m_address[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign bus.t_writedata = bus.m_writedata[int'(grant_idx)*DATA_W +: DATA_W];
    assign bus.t_byteena   = bus.m_byteena[int'(grant_idx)*BE_W +: BE_W];
    assign bus.m_readdata  = bus.t_readdata;

    always_comb begin
        bus.m_wait = '1;
        if (grant_vld) begin
            bus.m_wait[grant_idx] = bus.t_wait | (grant_rd & fifo_full);
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_idx_nxt = lock_idx;
        case (state)
            IDLE: begin
                if (grant_vld && !accept) begin
                    state_nxt    = LOCKED;
                    lock_idx_nxt = grant_idx;
                end
            end
            LOCKED: begin
                if (accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

    // t_read is already withheld when full, so an accepted read always has room.
    assign push = bus.t_read & ~bus.t_wait;
    assign pop  = bus.t_readdatavalid & (count != '0) & ~rst;

    always_comb begin
        bus.m_readdatavalid = '0;
        if (pop) begin
            bus.m_readdatavalid[tag_mem[head]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[tail] <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (bus.t_readdatavalid && count == '0) begin
                overflow_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter_n.sv
// Randomised bench for bus_arbiter_n against a queue-based reference model of the arbitration rules.
module tb_bus_arbiter_n;
    localparam int NM   = 3;
    localparam int AW   = 30;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 4;
    localparam int IW   = $clog2(NM);

    logic clk = 1'b0;
    logic rst;
    logic overflow_err;

    bus_arbiter_n_if #(.NMASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_arbiter_n #(
        .NMASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: FIFO of issuing master ids, currently held master, sticky error.
    int tags[$];
    int locked = -1;
    bit ovf    = 1'b0;

    // Per-master pending request, held until the model says it was accepted.
    bit              pend  [NM];
    bit              p_rd  [NM];
    bit              p_wr  [NM];
    logic [AW-1:0]   p_addr[NM];
    logic [DW-1:0]   p_data[NM];
    logic [BW-1:0]   p_be  [NM];

    // Stimulus knobs.
    bit          want_rst = 1'b1;
    logic [NM-1:0] req_mask = '0;
    int          p_req    = 0;
    int          p_wr_pct = 0;
    int          p_both   = 0;
    int          p_twait  = 0;
    int          p_rdv    = 0;
    bit          spurious = 1'b0;

    int cur_g;
    bit cur_wr, cur_rd, cur_full;

    task automatic drive();
        int r;
        rst = want_rst;
        for (int i = 0; i < NM; i++) begin
            if (!pend[i] && req_mask[IW'(i)] && $urandom_range(99) < p_req) begin
                r       = $urandom_range(99);
                pend[i] = 1'b1;
                p_wr[i] = (r < p_both + p_wr_pct);
                p_rd[i] = (r < p_both) || (r >= p_both + p_wr_pct);
                p_addr[i] = AW'($urandom);
                p_data[i] = DW'($urandom);
                p_be[i]   = BW'($urandom);
            end
            bus.m_read[IW'(i)]            = pend[i] & p_rd[i];
            bus.m_write[IW'(i)]           = pend[i] & p_wr[i];
            bus.m_address[i*AW +: AW]     = p_addr[i];
            bus.m_writedata[i*DW +: DW]   = p_data[i];
            bus.m_byteena[i*BW +: BW]     = p_be[i];
        end
        bus.t_wait     = ($urandom_range(99) < p_twait);
        bus.t_readdata = DW'($urandom);
        if (spurious) begin
            bus.t_readdatavalid = ($urandom_range(99) < p_rdv);
        end else begin
            bus.t_readdatavalid = (tags.size() > 0) && ($urandom_range(99) < p_rdv);
        end
    endtask

    task automatic check_outputs();
        logic [NM-1:0] ew, erdv;
        int gi;
        cur_g = -1;
        if (!rst) begin
            if (locked >= 0) begin
                cur_g = locked;
            end else begin
                for (int i = NM - 1; i >= 0; i--) begin
                    if (pend[i]) cur_g = i;
                end
            end
        end
        cur_wr   = (cur_g >= 0) && p_wr[cur_g];
        cur_rd   = (cur_g >= 0) && p_rd[cur_g] && !cur_wr;
        cur_full = (tags.size() == MAXO);
        ew = '1;
        if (cur_g >= 0) ew[IW'(cur_g)] = bus.t_wait | (cur_rd && cur_full);
        erdv = '0;
        if (!rst && bus.t_readdatavalid && tags.size() > 0) erdv[IW'(tags[0])] = 1'b1;
        gi = (cur_g < 0) ? 0 : cur_g;
        check_val("m_wait", 64'(bus.m_wait), 64'(ew));
        check_val("m_readdatavalid", 64'(bus.m_readdatavalid), 64'(erdv));
        check_val("m_readdata", 64'(bus.m_readdata), 64'(bus.t_readdata));
        check_val("t_read", 64'(bus.t_read), 64'(cur_rd && !cur_full));
        check_val("t_write", 64'(bus.t_write), 64'(cur_wr));
        check_val("t_address", 64'(bus.t_address), 64'(p_addr[gi]));
        check_val("t_writedata", 64'(bus.t_writedata), 64'(p_data[gi]));
        check_val("t_byteena", 64'(bus.t_byteena), 64'(p_be[gi]));
        check_val("overflow_err", 64'(overflow_err), 64'(ovf));
    endtask

    task automatic update_model();
        bit acc;
        if (rst) begin
            tags.delete();
            locked = -1;
            ovf    = 1'b0;
        end else begin
            acc = (cur_g >= 0) && !bus.t_wait && (cur_wr || (cur_rd && !cur_full));
            if (bus.t_readdatavalid) begin
                if (tags.size() > 0) void'(tags.pop_front());
                else ovf = 1'b1;
            end
            if (acc && cur_rd) tags.push_back(cur_g);
            if (acc) begin
                locked      = -1;
                pend[cur_g] = 1'b0;
            end else if (cur_g >= 0) begin
                locked = cur_g;
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        drive();
        #1;
        check_outputs();
        @(posedge clk);
        update_model();
    endtask

    task automatic set_read(input int i, input logic [AW-1:0] a);
        pend[i] = 1'b1; p_rd[i] = 1'b1; p_wr[i] = 1'b0;
        p_addr[i] = a; p_data[i] = '0; p_be[i] = '1;
    endtask

    initial begin
        rst = 1'b1;
        bus.m_read = '0; bus.m_write = '0; bus.m_address = '0;
        bus.m_writedata = '0; bus.m_byteena = '0;
        bus.t_wait = 1'b0; bus.t_readdata = '0; bus.t_readdatavalid = 1'b0;
        for (int i = 0; i < NM; i++) begin
            pend[i] = 0; p_rd[i] = 0; p_wr[i] = 0;
            p_addr[i] = '0; p_data[i] = '0; p_be[i] = '0;
        end

        // Reset state.
        repeat (2) run_cycle();
        #2;
        check_val("rst_m_wait", 64'(bus.m_wait), 64'h7);
        check_val("rst_t_read", 64'(bus.t_read), 64'h0);
        check_val("rst_overflow", 64'(overflow_err), 64'h0);
        want_rst = 1'b0;

        // Masters 0 and 2 read together: 0 first, then 2, data back in order.
        set_read(0, 30'h111);
        set_read(2, 30'h333);
        run_cycle();
        run_cycle();
        p_rdv = 100;
        repeat (3) run_cycle();
        p_rdv = 0;

        // Master 2 streams reads with no returns: fifo fills and the fifth read stalls.
        req_mask = 3'b100; p_req = 100; p_wr_pct = 0; p_both = 0; p_twait = 0;
        repeat (8) run_cycle();
        #2;
        check_val("full_t_read", 64'(bus.t_read), 64'h0);
        check_val("full_m_wait2", 64'(bus.m_wait[2]), 64'h1);
        p_rdv = 100;
        run_cycle();
        p_rdv = 0;
        run_cycle();

        // Reset with reads outstanding and no requests pending.
        req_mask = '0;
        for (int i = 0; i < NM; i++) pend[i] = 0;
        if (tags.size() < 3) check_val("outstanding_before_rst", 64'(tags.size()), 64'h3);
        want_rst = 1'b1;
        run_cycle();
        want_rst = 1'b0;
        run_cycle();
        #2;
        check_val("post_rst_m_wait", 64'(bus.m_wait), 64'h7);
        check_val("post_rst_t_read", 64'(bus.t_read), 64'h0);
        check_val("post_rst_overflow", 64'(overflow_err), 64'h0);

        // Random traffic with mixed commands, target stalls and returns.
        req_mask = '1; p_req = 40; p_wr_pct = 40; p_both = 5; p_twait = 30; p_rdv = 40;
        repeat (1500) run_cycle();
        p_twait = 0; p_rdv = 15; p_wr_pct = 10;
        repeat (800) run_cycle();

        // Drain, then strobe read data with nothing outstanding.
        req_mask = '0; p_rdv = 100;
        for (int n = 0; n < 200 && (tags.size() > 0 || pend[0] || pend[1] || pend[2]); n++) run_cycle();
        if (tags.size() != 0) check_val("drain_timeout", 64'(tags.size()), 64'h0);
        spurious = 1'b1;
        run_cycle();
        spurious = 1'b0;
        #2;
        check_val("overflow_set", 64'(overflow_err), 64'h1);

        // Error stays sticky under further traffic until reset.
        req_mask = '1; p_req = 40; p_twait = 20; p_rdv = 40;
        repeat (300) run_cycle();
        #2;
        check_val("overflow_sticky", 64'(overflow_err), 64'h1);
        req_mask = '0;
        for (int i = 0; i < NM; i++) pend[i] = 0;
        want_rst = 1'b1;
        run_cycle();
        want_rst = 1'b0;
        run_cycle();
        #2;
        check_val("overflow_cleared", 64'(overflow_err), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
